// File: rtl/fma_issue_ctrl.sv
// ============================================================================
// Module   : fma_issue_ctrl
// Purpose  : Issue/collect stage around the combinational fpfma datapath.
//            Accepts one FMA operation over a valid/ready handshake and
//            registers the operands onto the fpfma inputs. It holds them for
//            SETTLE_CYCLES cycles, then captures fpfma's result into an output
//            register. The result is offered downstream over a second
//            valid/ready handshake.
//
// Ports    : clk, rst                   clock, synchronous active-high reset
//            in_valid/in_ready          operation handshake
//            in_a, in_b, in_c, in_rnd   operands and rounding mode
//            in_op                      (FMA_OP_SUB_EN only) 0: A*B+C, 1: A*B-C
//            fma_a/b/c, fma_rnd         registered operands to fpfma
//            fma_result                 combinational result from fpfma
//            out_valid/out_ready        result handshake
//            out_result                 registered result
//            busy                       high whenever not IDLE
//            done_count                 results consumed, wraps silently
//
// Options  : `define FMA_OP_SUB_EN to add the in_op port (subtract addend).
//
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fma_issue_ctrl #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [WIDTH-1:0]     in_c,
   input  logic [1:0]           in_rnd,
`ifdef FMA_OP_SUB_EN
   input  logic                 in_op,
`endif
   output logic [WIDTH-1:0]     fma_a,
   output logic [WIDTH-1:0]     fma_b,
   output logic [WIDTH-1:0]     fma_c,
   output logic [1:0]           fma_rnd,
   input  logic [WIDTH-1:0]     fma_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] done_count
);

   // Settle counter only needs to hold SETTLE_CYCLES-1; keep at least 1 bit.
   localparam int CTR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CTR_W-1:0] settle_cnt;
   logic             accept;
   logic [WIDTH-1:0] c_load;

   // A new operation may enter while the previous result is being consumed.
   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

`ifdef FMA_OP_SUB_EN
   // Subtraction is done by flipping the addend's sign bit before fpfma.
   assign c_load = in_op ? {~in_c[WIDTH-1], in_c[WIDTH-2:0]} : in_c;
`else
   assign c_load = in_c;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         fma_a      <= '0;
         fma_b      <= '0;
         fma_c      <= '0;
         fma_rnd    <= '0;
         out_result <= '0;
         out_valid  <= 1'b0;
         done_count <= '0;
      end else begin
         // Operands change only on accept, so fpfma inputs are stable
         // throughout EXEC and DONE.
         if (accept) begin
            fma_a      <= in_a;
            fma_b      <= in_b;
            fma_c      <= c_load;
            fma_rnd    <= in_rnd;
            settle_cnt <= CTR_LOAD;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - 1'b1;
               end else begin
                  out_result <= fma_result;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  done_count <= done_count + 1'b1;
                  out_valid  <= 1'b0;
                  // in_ready is necessarily high here, so in_valid implies accept.
                  state      <= accept ? EXEC : IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/fma_issue_ctrl.md
Name: fma_issue_ctrl

Overview:
- Sequential issue/collect stage that wraps the combinational fpfma datapath.
- Accepts one FMA operation (A, B, C, rnd) per transaction over a valid/ready input handshake and registers the operands.
- Holds the operands stable on the fpfma inputs for a parameterised multicycle settle window, then samples fpfma's result into an output register.
- Presents the sampled result over a valid/ready output handshake. fpfma sits directly downstream of the operand registers and upstream of the result register.

Parameters:
- WIDTH, 32, floating-point word width; matches fpfma WIDTH.
- SETTLE_CYCLES, 2, number of clock cycles the operands are held before the result is sampled; legal range is at least 1.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_c  input  WIDTH  addend C.
- in_rnd  input  2  rounding mode (00 RZ, 01 RN, 10 +Inf, 11 -Inf).
- fma_a  output  WIDTH  registered A to fpfma.
- fma_b  output  WIDTH  registered B to fpfma.
- fma_c  output  WIDTH  registered C to fpfma.
- fma_rnd  output  2  registered rounding mode to fpfma.
- fma_result  input  WIDTH  combinational result from fpfma.
- out_valid  output  1  out_result holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  registered result.
- busy  output  1  high in any state other than IDLE.
- done_count  output  CNT_WIDTH  number of results consumed downstream; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst high at a clock edge) sets:
  - state to IDLE;
  - fma_a, fma_b, fma_c, fma_rnd, out_result and the settle counter to 0;
  - out_valid to 0 and done_count to 0.
- in_ready is forced to 0 whenever rst is high. Reset mid-operation discards the operation in flight and any pending result.
- States are IDLE, EXEC and DONE.
- in_ready (combinational) = !rst && (state==IDLE || (state==DONE && out_ready)).
- An operation is accepted on a clock edge where in_valid && in_ready. On acceptance:
  - operand registers load in_a, in_b, in_c, in_rnd;
  - counter loads SETTLE_CYCLES-1;
  - state goes to EXEC.
- IDLE: out_valid=0, busy=0. Transitions to EXEC on accept; otherwise stays in IDLE.
- EXEC: in_ready=0 and operand registers hold.
  - If counter != 0: decrement it.
  - If counter == 0: out_result <= fma_result, out_valid <= 1, state goes to DONE.
- DONE: out_valid=1 and out_result is held stable until consumed.
  - out_ready=0: stay in DONE. Operand registers and the result hold.
  - out_ready=1 and in_valid=1 (simultaneous consume and accept): done_count increments, the new operands load, out_valid <= 0, state goes to EXEC.
  - out_ready=1 and in_valid=0: done_count increments, out_valid <= 0, state goes to IDLE.
- Latency: for an accept on edge k, the result is sampled on edge k+SETTLE_CYCLES and out_valid is high in the following cycle.
- Throughput: with out_ready held high, one operation completes every SETTLE_CYCLES+1 cycles.
- Operand registers change only on accept, so fma_* stay stable through EXEC and DONE.
- in_* inputs are ignored when not accepted. out_ready is ignored outside DONE.
- done_count wraps from all-ones to 0 with no flag.
- Results are passed through bit-exact; the block performs no arithmetic on operands or result.

Optional Feature:
- Macro: FMA_OP_SUB_EN.
- Defined:
  - adds port in_op (input, 1 bit), sampled on accept together with the operands;
  - in_op=0 selects A*B+C; in_op=1 selects A*B-C;
  - for in_op=1, fma_c is loaded with in_c with bit WIDTH-1 inverted.
- Not defined: port in_op does not exist and fma_c loads in_c unchanged.

Test Plan:
- Reset, then single operation:
  - stimulus: rst high 2 cycles; then in_a=0x3F800000, in_b=0x40000000, in_c=0x40400000, in_rnd=01, with fpfma connected;
  - required: out_valid rises SETTLE_CYCLES edges after accept (1 cycle after the sampling edge); out_result=0x40A00000; done_count goes 0->1 after out_ready.
- Backpressure:
  - stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with different operands;
  - required: in_ready=0, out_result is unchanged, fma_a/b/c are unchanged, out_valid stays 1.
- Back-to-back:
  - stimulus: out_ready=1 and in_valid=1 continuously for 4 operations, SETTLE_CYCLES=2;
  - required: results arrive every 3 cycles in issue order; done_count=4.
- Reset mid-EXEC:
  - stimulus: assert rst one cycle after accept;
  - required: next cycle state is IDLE, out_valid=0, fma_a=0, done_count=0, and no result is ever emitted.
- Counter wrap:
  - stimulus: CNT_WIDTH=4, complete 17 operations;
  - required: done_count=1.
- FMA_OP_SUB_EN defined:
  - stimulus: in_op=1, in_c=0x40400000;
  - required: fma_c=0xC0400000. The same stimulus with in_op=0 gives fma_c=0x40400000.
